fifo_write_arbiter: RTL and testbench
=====================================

// Module: fifo_write_arbiter
// PURPOSE
//  Round-robin scheduler sharing the write port of async_fifo_combine between NREQ
//  write-domain requesters. Grants one requester per burst, optionally prefixes each
//  burst with a source-tag word, honours wfull/awfull backpressure from FIFO1, and caps
//  bursts at MAXBURST beats to bound latency for other requesters.
// PARAMETERS
//  DSIZE     32  data width, matches FIFO DSIZE
//  NREQ       4  number of requesters (>=2)
//  MAXBURST  16  max data beats per grant (>=1)
//  TAG_EN     1  1: emit header word before each burst; 0: no header
// PORTS (IDW = $clog2(NREQ))
//  wclk       in   1           write-domain clock
//  wrst       in   1           asynchronous active-high reset
//  req_valid  in   NREQ        per-requester beat valid
//  req_data   in   NREQ*DSIZE  per-requester data, requester i at [i*DSIZE +: DSIZE]
//  req_last   in   NREQ        final beat of requester's burst
//  req_ready  out  NREQ        beat accepted when valid&ready
//  wfull      in   1           FIFO1 full
//  awfull     in   1           FIFO1 almost full
//  winc       out  1           FIFO write enable
//  wdata      out  DSIZE       FIFO write data
//  grant_id   out  IDW         current or last granted requester
//  busy       out  1           high in HDR or BURST
// BEHAVIOUR
//  - Reset: state=IDLE, rr_ptr=NREQ-1, beat_cnt=0, grant_id=0; winc=0, req_ready=0, busy=0.
//    Reset asserted mid-burst aborts the burst; no partial-beat write after reset edge.
//  - FSM states IDLE, HDR, BURST; registered on wclk.
//  - IDLE: if any req_valid and !awfull, pick first valid index after rr_ptr (mod NREQ),
//    latch grant_id, go HDR (TAG_EN=1) or BURST (TAG_EN=0). Arbitration takes 1 cycle;
//    no write occurs in IDLE. awfull=1 blocks new grants only, never an open burst.
//  - HDR: winc = !wfull; wdata = {1'b1, zeros, grant_id} (MSB set, id in LSBs).
//    Advance to BURST on the cycle winc=1; otherwise hold.
//  - BURST: req_ready[grant_id] = !wfull; all other req_ready bits 0.
//    winc = req_valid[grant_id] & !wfull; wdata = req_data[grant_id] (combinational mux).
//    Each accepted beat increments beat_cnt. Burst ends on accepted beat with
//    req_last=1 or beat_cnt reaching MAXBURST -> IDLE, rr_ptr <= grant_id, beat_cnt <= 0.
//  - Capped burst (no last): requester keeps remaining data; re-arbitrates normally
//    (other valid requesters served first); a new header precedes its continuation.
//  - Granted requester dropping valid mid-burst: grant held, winc=0, no timeout.
//  - winc, wdata, req_ready are combinational from registered state + wfull/valid;
//    0-cycle latency from beat accept to FIFO write. winc never asserted while wfull=1.
//  - beat_cnt width $clog2(MAXBURST+1); never exceeds MAXBURST.
//  - Non-granted requesters are never acknowledged; beat ordering per requester kept.
//  - grant_id holds its value in IDLE (last grant) and is 0 after reset.
// TESTING
//  1 TAG_EN=1, req0 sends A,B,C (last on C) -> wdata 0x80000000,A,B,C with winc each; busy falls, IDLE.
//  2 All 4 valid, 2-beat bursts each, repeated -> header ids in order 0,1,2,3,0; no interleave.
//  3 wfull=1 for 5 cycles mid-burst req2 -> winc=0, req_ready=0 throughout; all beats written once, in order.
//  4 req1 streams 20 beats no last, req3 valid -> 16 req1 beats, then req3 burst, then req1 last 4 beats with new header.
//  5 awfull=1 in IDLE with req0 valid -> busy=0 indefinitely; awfull falls -> HDR next cycle.
//  6 wrst pulse during req2 beat 3 -> all outputs 0 immediately; after release req0,req2 valid -> req0 granted first.

Source files
------------

// File: rtl/fifo_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : fifo_write_arbiter                                             |
// | Brief   : Round-robin burst arbiter for a shared FIFO write port, with   |
// |           optional source-tag header and MAXBURST beat cap.              |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module fifo_write_arbiter #(
    parameter int DSIZE    = 32,
    parameter int NREQ     = 4,
    parameter int MAXBURST = 16,
    parameter int TAG_EN   = 1
) (
    input  logic                      wclk,
    input  logic                      wrst,
    input  logic [NREQ-1:0]           req_valid,
    input  logic [NREQ*DSIZE-1:0]     req_data,
    input  logic [NREQ-1:0]           req_last,
    output logic [NREQ-1:0]           req_ready,
    input  logic                      wfull,
    input  logic                      awfull,
    output logic                      winc,
    output logic [DSIZE-1:0]          wdata,
    output logic [$clog2(NREQ)-1:0]   grant_id,
    output logic                      busy
);

    localparam int IDW = $clog2(NREQ);
    localparam int CW  = $clog2(MAXBURST + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_HDR   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [IDW-1:0]   r_rr_ptr;
    logic [IDW-1:0]   r_grant_id;
    logic [CW-1:0]    r_beat_cnt;
    logic [CW-1:0]    w_cnt_nxt;

    logic             w_any;
    logic [IDW-1:0]   w_pick;
    int               w_best;
    int               w_dist;

    logic             w_sel_valid;
    logic             w_sel_last;
    logic [DSIZE-1:0] w_sel_data;
    logic [DSIZE-1:0] w_hdr;
    logic             w_grant;
    logic             w_accept;
    logic             w_end;

    // Distance counted forward from rr_ptr; smallest distance among valid wins.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_best = 2 * NREQ;
        w_dist = 0;
        for (int i = 0; i < NREQ; i++) begin
            w_dist = (i > int'(r_rr_ptr)) ? (i - int'(r_rr_ptr))
                                          : (i + NREQ - int'(r_rr_ptr));
            if (req_valid[i] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_pick = IDW'(i);
                w_any  = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_valid = 1'b0;
        w_sel_last  = 1'b0;
        w_sel_data  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (IDW'(i) == r_grant_id) begin
                w_sel_valid = req_valid[i];
                w_sel_last  = req_last[i];
                w_sel_data  = req_data[i*DSIZE +: DSIZE];
            end
        end
    end

    always_comb begin
        w_hdr              = '0;
        w_hdr[DSIZE-1]     = 1'b1;
        w_hdr[IDW-1:0]     = r_grant_id;
    end

    assign w_grant   = (r_state == S_IDLE) && w_any && !awfull;
    assign w_accept  = (r_state == S_BURST) && w_sel_valid && !wfull;
    assign w_cnt_nxt = r_beat_cnt + CW'(1);
    assign w_end     = w_accept && (w_sel_last || (w_cnt_nxt == CW'(MAXBURST)));

    always_comb begin
        w_state_nxt = r_state;
        winc        = 1'b0;
        wdata       = '0;
        req_ready   = '0;
        case (r_state)
            S_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = (TAG_EN != 0) ? S_HDR : S_BURST;
                end
            end
            S_HDR: begin
                winc  = !wfull;
                wdata = w_hdr;
                if (!wfull) begin
                    w_state_nxt = S_BURST;
                end
            end
            S_BURST: begin
                for (int i = 0; i < NREQ; i++) begin
                    req_ready[i] = (IDW'(i) == r_grant_id) && !wfull;
                end
                winc  = w_accept;
                wdata = w_sel_data;
                if (w_end) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge wclk or posedge wrst) begin
        if (wrst) begin
            r_state    <= S_IDLE;
            r_rr_ptr   <= IDW'(NREQ - 1);
            r_beat_cnt <= '0;
            r_grant_id <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_grant) begin
                r_grant_id <= w_pick;
            end
            if (w_end) begin
                r_beat_cnt <= '0;
                r_rr_ptr   <= r_grant_id;
            end else if (w_accept) begin
                r_beat_cnt <= w_cnt_nxt;
            end
        end
    end

    assign grant_id = r_grant_id;
    assign busy     = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_fifo_write_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module  : tb_fifo_write_arbiter                                          |
// | Brief   : Scoreboard bench: per-requester sources, FIFO-write monitor.   |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
module tb_fifo_write_arbiter;

    localparam int DSIZE = 32;
    localparam int NREQ  = 4;

    logic                   wclk;
    logic                   wrst;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*DSIZE-1:0]  req_data;
    logic [NREQ-1:0]        req_last;
    logic [NREQ-1:0]        req_ready;
    logic                   wfull;
    logic                   awfull;
    logic                   winc;
    logic [DSIZE-1:0]       wdata;
    logic [1:0]             grant_id;
    logic                   busy;

    fifo_write_arbiter #(
        .DSIZE(DSIZE), .NREQ(NREQ), .MAXBURST(16), .TAG_EN(1)
    ) dut (
        .wclk(wclk), .wrst(wrst), .req_valid(req_valid), .req_data(req_data),
        .req_last(req_last), .req_ready(req_ready), .wfull(wfull), .awfull(awfull),
        .winc(winc), .wdata(wdata), .grant_id(grant_id), .busy(busy)
    );

    initial wclk = 1'b0;
    always #5 wclk = ~wclk;

    int          n_checks = 0;
    int          n_errors = 0;
    int          n_writes = 0;
    logic [31:0] exp_q[$];
    logic [32:0] src_mem [NREQ][64];
    int          src_rd [NREQ];
    int          src_wr [NREQ];
    logic [NREQ-1:0] acc = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, expv);
        end
    endtask

    task automatic src_push(input int r, input logic [31:0] d, input logic last);
        src_mem[r][src_wr[r]] = {last, d};
        src_wr[r]++;
    endtask

    function automatic logic [31:0] dat(input int r, input int n);
        return 32'hA000_0000 | (r << 16) | n;
    endfunction

    // Requester sources: pop on the beat accepted at the previous edge.
    initial begin
        for (int i = 0; i < NREQ; i++) begin src_rd[i] = 0; src_wr[i] = 0; end
        req_valid = '0; req_data = '0; req_last = '0;
        forever begin
            @(posedge wclk); #1;
            for (int i = 0; i < NREQ; i++) begin
                if (acc[i]) src_rd[i]++;
                req_valid[i] = (src_rd[i] < src_wr[i]);
                req_data[i*DSIZE +: DSIZE] = src_mem[i][src_rd[i]][31:0];
                req_last[i] = src_mem[i][src_rd[i]][32];
            end
        end
    end

    // Monitor: every FIFO write is compared against the expected stream.
    initial begin
        forever begin
            @(negedge wclk);
            acc = req_valid & req_ready;
            if (winc) begin
                n_writes++;
                chk("winc_while_full", {31'b0, wfull}, 32'h0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", wdata, 32'hxxxx_xxxx);
                end else begin
                    chk("wdata", wdata, exp_q.pop_front());
                end
            end
        end
    end

    task automatic do_reset();
        @(posedge wclk); #2;
        wrst = 1'b1;
        for (int i = 0; i < NREQ; i++) begin src_rd[i] = 0; src_wr[i] = 0; end
        @(posedge wclk); #1;
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_winc", {31'b0, winc}, 32'h0);
        chk("rst_ready", {28'b0, req_ready}, 32'h0);
        chk("rst_grant", {30'b0, grant_id}, 32'h0);
        @(posedge wclk); #2;
        wrst = 1'b0;
    endtask

    task automatic wait_drain();
        int c = 0;
        while (exp_q.size() != 0 && c < 400) begin @(posedge wclk); c++; end
        chk("drain_timeout", exp_q.size(), 32'h0);
        @(posedge wclk);
    endtask

    task automatic wait_writes(input int target);
        int c = 0;
        while (n_writes < target && c < 400) begin @(posedge wclk); c++; end
        chk("writes_timeout", {31'b0, (n_writes >= target)}, 32'h1);
    endtask

    initial begin
        wrst = 1'b0; wfull = 1'b0; awfull = 1'b0;

        // 1: single burst from req0 with header
        do_reset();
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(32'h0000_000A);
        exp_q.push_back(32'h0000_000B);
        exp_q.push_back(32'h0000_000C);
        src_push(0, 32'h0000_000A, 1'b0);
        src_push(0, 32'h0000_000B, 1'b0);
        src_push(0, 32'h0000_000C, 1'b1);
        wait_drain();
        @(negedge wclk);
        chk("t1_busy_idle", {31'b0, busy}, 32'h0);
        chk("t1_grant", {30'b0, grant_id}, 32'h0);

        // 2: all four requesters, two 2-beat bursts each
        do_reset();
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NREQ; i++) begin
                exp_q.push_back(32'h8000_0000 | i);
                exp_q.push_back(dat(i, 2*r));
                exp_q.push_back(dat(i, 2*r + 1));
                src_push(i, dat(i, 2*r), 1'b0);
                src_push(i, dat(i, 2*r + 1), 1'b1);
            end
        end
        wait_drain();

        // 3: wfull held 5 cycles in the middle of a req2 burst
        do_reset();
        exp_q.push_back(32'h8000_0002);
        for (int n = 0; n < 6; n++) begin
            exp_q.push_back(dat(2, n));
            src_push(2, dat(2, n), n == 5);
        end
        wait_writes(n_writes + 3);
        #1 wfull = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge wclk);
            chk("t3_winc_full", {31'b0, winc}, 32'h0);
            chk("t3_ready_full", {28'b0, req_ready}, 32'h0);
            @(posedge wclk);
        end
        #1 wfull = 1'b0;
        wait_drain();

        // 4: req1 capped at 16 beats, req3 served, then req1 continues
        do_reset();
        exp_q.push_back(32'h8000_0001);
        for (int n = 0; n < 16; n++) exp_q.push_back(dat(1, n));
        exp_q.push_back(32'h8000_0003);
        exp_q.push_back(dat(3, 0));
        exp_q.push_back(dat(3, 1));
        exp_q.push_back(32'h8000_0001);
        for (int n = 16; n < 20; n++) exp_q.push_back(dat(1, n));
        for (int n = 0; n < 20; n++) src_push(1, dat(1, n), n == 19);
        src_push(3, dat(3, 0), 1'b0);
        src_push(3, dat(3, 1), 1'b1);
        wait_drain();
        @(negedge wclk);
        chk("t4_last_grant", {30'b0, grant_id}, 32'h1);

        // 5: awfull blocks new grant until released
        do_reset();
        awfull = 1'b1;
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(dat(0, 0));
        exp_q.push_back(dat(0, 1));
        src_push(0, dat(0, 0), 1'b0);
        src_push(0, dat(0, 1), 1'b1);
        for (int k = 0; k < 6; k++) begin
            @(negedge wclk);
            chk("t5_busy_blocked", {31'b0, busy}, 32'h0);
        end
        @(posedge wclk); #1 awfull = 1'b0;
        @(posedge wclk);
        @(negedge wclk);
        chk("t5_busy_hdr", {31'b0, busy}, 32'h1);
        wait_drain();

        // 6: reset during req2 beat 3, then req0 wins over req2
        do_reset();
        exp_q.push_back(32'h8000_0002);
        exp_q.push_back(dat(2, 0));
        exp_q.push_back(dat(2, 1));
        for (int n = 0; n < 5; n++) src_push(2, dat(2, n), n == 4);
        wait_writes(n_writes + 3);
        #2 wrst = 1'b1;
        #1;
        chk("t6_winc", {31'b0, winc}, 32'h0);
        chk("t6_busy", {31'b0, busy}, 32'h0);
        chk("t6_ready", {28'b0, req_ready}, 32'h0);
        chk("t6_grant", {30'b0, grant_id}, 32'h0);
        chk("t6_pending", exp_q.size(), 32'h0);
        for (int i = 0; i < NREQ; i++) begin src_rd[i] = 0; src_wr[i] = 0; end
        @(posedge wclk); #2 wrst = 1'b0;
        exp_q.push_back(32'h8000_0000);
        exp_q.push_back(dat(0, 7));
        exp_q.push_back(dat(0, 8));
        exp_q.push_back(32'h8000_0002);
        exp_q.push_back(dat(2, 7));
        exp_q.push_back(dat(2, 8));
        src_push(0, dat(0, 7), 1'b0);
        src_push(0, dat(0, 8), 1'b1);
        src_push(2, dat(2, 7), 1'b0);
        src_push(2, dat(2, 8), 1'b1);
        wait_drain();
        repeat (3) @(posedge wclk);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
